data_mem_arbiter: RTL

Two-port arbiter and sequencer for the byte-addressed, big-endian data memory. It shares the single memory port between the pipeline MEM stage (port 0, priority) and the program/debug loader (port 1). An aging counter bounds loader starvation, and misaligned or out-of-range word accesses are rejected before they reach memory. Each requester gets a registered, one-cycle-latency response with read data or write acknowledge.

---
 rtl/data_mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one big-endian word memory port between the
// pipeline MEM stage (port 0, priority) and the loader (port 1). An aging
// counter bounds loader starvation; bad word addresses are rejected before
// they reach memory and answered with an error response.

// Per-port response register: captures the outcome of a grant to this port.
module data_mem_arbiter_rsp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gnt,
  input  logic        legal,
  input  logic        rd,
  input  logic [31:0] mem_rdata,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        rerr
);
  // rvalid/rerr track the grant every cycle; rdata only moves on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rerr   <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= gnt;
      rerr   <= gnt & ~legal;
      if (gnt) rdata <= rd ? mem_rdata : '0;
    end
  end
endmodule

module data_mem_arbiter #(
  parameter int DEPTH    = 1024,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        rerr0,
  output logic        rerr1,
  output logic        stall0,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  err_cnt
);
  localparam int          NP        = 2;
  localparam logic [31:0] LAST_WORD = 32'(DEPTH - 4);
  localparam logic [7:0]  WAIT_MAX  = 8'(MAX_WAIT);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t                 sel;
  logic [NP-1:0]        gnt, rvalid, rerr;
  logic [NP-1:0][31:0]  rdata;
  logic [7:0]           wait_cnt;
  logic                 force1, any_gnt, legal, rd_ok;

  // Grants are gated by rst_n so nothing reaches memory while in reset
  assign force1  = req1 & (wait_cnt == WAIT_MAX);
  assign gnt[1]  = rst_n & req1 & (force1 | ~req0);
  assign gnt[0]  = rst_n & req0 & ~gnt[1];
  assign any_gnt = |gnt;
  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign stall0  = req0 & ~gnt[0];

  // Route the granted port's access onto the memory side; idle drives zeros
  always_comb begin
    sel = '0;
    if (gnt[1])      sel = {we1, addr1, wdata1};
    else if (gnt[0]) sel = {we0, addr0, wdata0};
  end

  assign legal     = (sel.addr[1:0] == 2'b00) & (sel.addr <= LAST_WORD);
  assign rd_ok     = any_gnt & legal & ~sel.we;
  assign mem_read  = rd_ok;
  assign mem_write = any_gnt & legal & sel.we;
  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;

  // Aging: count denied loader cycles up to MAX_WAIT, clear on grant or idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt <= '0;
    else if (req1 & ~gnt[1]) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 8'd1;
    end else                    wait_cnt <= '0;
  end

  // Saturating count of rejected (granted but illegal) accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     err_cnt <= '0;
    else if (any_gnt & ~legal & (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
  end

  for (genvar p = 0; p < NP; p++) begin : g_rsp
    data_mem_arbiter_rsp u_rsp (
      .clk       (clk),
      .rst_n     (rst_n),
      .gnt       (gnt[p]),
      .legal     (legal),
      .rd        (rd_ok),
      .mem_rdata (mem_rdata),
      .rvalid    (rvalid[p]),
      .rdata     (rdata[p]),
      .rerr      (rerr[p])
    );
  end

  assign rvalid0 = rvalid[0];
  assign rvalid1 = rvalid[1];
  assign rdata0  = rdata[0];
  assign rdata1  = rdata[1];
  assign rerr0   = rerr[0];
  assign rerr1   = rerr[1];
endmodule
